window_ctrl: RTL and testbench
==============================

Name: window_ctrl

Overview:
- Sequencer for the line-buffer/kernel-window datapath in the streaming filter pipeline.
- Tracks raster position of the incoming pixel stream and gates the row buffer's enable.
- Flags when the kernel output holds a complete, in-frame window, and reports its coordinates to downstream filter stages.
- Handles frame start/end, stalls and mid-frame restarts.

Parameters:
- rowWidth, 640: pixels per line; must match the row buffer.
- frameHeight, 480: lines per frame.
- kernelSize, 7: window edge length; valid range is 3 to rowWidth.
- coordBits, 10: width of the coordinate outputs; must be at least clog2(max(rowWidth, frameHeight)).

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- frameStart  in  1  one-cycle pulse; marks the current cycle as the first pixel slot of a frame
- pixelValid  in  1  an input pixel is present this cycle
- bufEnable  out  1  row buffer enable (shift/capture)
- bufClear  out  1  one-cycle pulse; synchronous clear request to the row buffer
- windowValid  out  1  the kernel output holds a complete window this cycle
- winRow  out  coordBits  row of the window's bottom-right pixel
- winCol  out  coordBits  column of the window's bottom-right pixel
- frameDone  out  1  one-cycle pulse after the last pixel of a frame is accepted
- frameAbort  out  1  one-cycle pulse when a frame is restarted before it completed
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; row/col counters=0.
  - All outputs 0, including winRow/winCol.
- States: IDLE, PRIME, STREAM, DONE. Encoding is free.
- Accepted beat: pixelValid=1 and state is PRIME or STREAM, or frameStart=1 in any state.
  - bufEnable is combinational and equals the accepted-beat condition.
  - pixelValid=0 stalls everything: counters and state hold, bufEnable=0.
- Counters:
  - col increments on each accepted beat and wraps from rowWidth-1 to 0, incrementing row.
  - Counters describe the position of the pixel being accepted.
- IDLE:
  - pixelValid without frameStart is ignored (dropped); bufEnable=0.
  - frameStart=1: bufClear pulses the same cycle, counters are forced so the frameStart-cycle pixel (if pixelValid=1) is row 0 col 0, and the next state is PRIME.
  - frameStart with pixelValid=0: counters reset, no pixel consumed.
- PRIME: go to STREAM when an accepted beat wraps the last column of row kernelSize-2.
- STREAM: the accepted beat at row=frameHeight-1, col=rowWidth-1 moves the state to DONE.
- DONE:
  - frameDone=1 for exactly this one cycle; next state is IDLE.
  - A frameStart in DONE is honoured as in IDLE; frameDone still pulses.
- windowValid, winRow, winCol:
  - Registered, one cycle after the accepted beat at (r,c) with r>=kernelSize-1 and c>=kernelSize-1.
  - winRow=r, winCol=c; coordinates hold their last value when windowValid=0.
  - Windows per frame = (rowWidth-kernelSize+1)*(frameHeight-kernelSize+1).
- frameStart while in PRIME or STREAM:
  - frameAbort and bufClear pulse.
  - Counters restart as from IDLE; the state becomes PRIME.
  - Any windowValid for the prior beat still issues.
- kernelSize=1 degenerate case is unsupported.
- Counter widths: clog2(rowWidth) and clog2(frameHeight). Comparisons against parameters are done in full width with no truncation.

Optional Feature:
- Macro: WINDOW_CTRL_STATS_EN.
- Defined:
  - Adds outputs dropCount[15:0] and abortCount[15:0], both reset to 0.
  - dropCount increments on each pixelValid=1 cycle in IDLE or DONE that is not a frameStart cycle.
  - abortCount increments with each frameAbort pulse.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports are absent and no counter logic is present.

Test Plan (rowWidth=8, frameHeight=6, kernelSize=3, coordBits=4):
- Reset, then a continuous frame of 48 pixels from frameStart:
  - Exactly 24 windowValid pulses.
  - First pulse has winRow=2, winCol=2, arriving one cycle after the 19th accepted pixel.
  - Last pulse has winRow=5, winCol=7.
  - frameDone pulses once, one cycle after the 48th beat; busy falls the cycle after.
- Same frame with pixelValid deasserted every third cycle:
  - Identical windowValid coordinate sequence (24 windows).
  - bufEnable=0 on every stall cycle; the counters hold.
- 5 pixelValid beats in IDLE, then a frame:
  - bufEnable=0 for the first 5 beats.
  - With STATS_EN, dropCount=5; first window still (2,2).
- frameStart at row 3 col 4 mid-frame:
  - frameAbort=1 and bufClear=1 for one cycle; state PRIME.
  - Next window is (2,2) of the new frame; abortCount=1 with STATS_EN.
- Assert reset_n=0 asynchronously mid-STREAM, between clock edges:
  - All outputs drop to 0 immediately.
  - After release, pixels without frameStart are ignored until frameStart.
- frameStart in the DONE cycle:
  - frameDone=1 that cycle and new frame accepted as row 0 col 0.
  - No frameAbort.

Source files
------------

// File: rtl/window_ctrl_if.sv
// window_ctrl_if: pixel-stream handshake and window report bundle for window_ctrl.
// dropCount/abortCount exist only when WINDOW_CTRL_STATS_EN is defined.
interface window_ctrl_if #(
  parameter int coordBits = 10
) ();
  logic                 frameStart;
  logic                 pixelValid;
  logic                 bufEnable;
  logic                 bufClear;
  logic                 windowValid;
  logic [coordBits-1:0] winRow;
  logic [coordBits-1:0] winCol;
  logic                 frameDone;
  logic                 frameAbort;
  logic                 busy;
`ifdef WINDOW_CTRL_STATS_EN
  logic [15:0]          dropCount;
  logic [15:0]          abortCount;
  modport master (output frameStart, pixelValid,
                  input bufEnable, bufClear, windowValid, winRow, winCol,
                        frameDone, frameAbort, busy, dropCount, abortCount);
  modport slave  (input frameStart, pixelValid,
                  output bufEnable, bufClear, windowValid, winRow, winCol,
                         frameDone, frameAbort, busy, dropCount, abortCount);
`else
  modport master (output frameStart, pixelValid,
                  input bufEnable, bufClear, windowValid, winRow, winCol,
                        frameDone, frameAbort, busy);
  modport slave  (input frameStart, pixelValid,
                  output bufEnable, bufClear, windowValid, winRow, winCol,
                         frameDone, frameAbort, busy);
`endif
endinterface

// File: rtl/window_ctrl.sv
// window_ctrl: raster sequencer gating the row buffer and flagging complete kernel windows.
// Optional WINDOW_CTRL_STATS_EN adds saturating dropped-pixel and frame-abort counters.
module window_ctrl #(
  parameter int rowWidth    = 640,
  parameter int frameHeight = 480,
  parameter int kernelSize  = 7,
  parameter int coordBits   = 10
) (
  input  logic clk,
  input  logic reset_n,
  window_ctrl_if.slave bus
);
  localparam int CB = rowWidth > 1 ? $clog2(rowWidth) : 1;
  localparam int RB = frameHeight > 1 ? $clog2(frameHeight) : 1;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
  state_t               state_q, state_d;
  logic [CB-1:0]        col_q, col_d, pos_col;
  logic [RB-1:0]        row_q, row_d, pos_row;
  logic                 active, acc, pix, last_col, last_row, last_prime, win_d;
  logic                 win_valid_q, frame_done_q, busy_q;
  logic [coordBits-1:0] win_row_q, win_col_q;
  // A frameStart slot is always pixel (0,0); otherwise the counters name the pixel now offered.
  always_comb begin
    active     = state_q == PRIME || state_q == STREAM;
    acc        = reset_n && (bus.frameStart || (bus.pixelValid && active));
    pix        = acc && bus.pixelValid;
    pos_col    = bus.frameStart ? '0 : col_q;
    pos_row    = bus.frameStart ? '0 : row_q;
    last_col   = int'(pos_col) == rowWidth - 1;
    last_row   = int'(pos_row) == frameHeight - 1;
    last_prime = int'(pos_row) == kernelSize - 2 && last_col;
    win_d      = pix && int'(pos_row) >= kernelSize - 1 && int'(pos_col) >= kernelSize - 1;
    col_d      = pix ? (last_col ? '0 : pos_col + 1'b1) : pos_col;
    row_d      = pix && last_col ? (last_row ? '0 : pos_row + 1'b1) : pos_row;
    state_d    = bus.frameStart ? PRIME :
                 state_q == PRIME  ? (pix && last_prime ? STREAM : PRIME) :
                 state_q == STREAM ? (pix && last_row && last_col ? DONE : STREAM) :
                 IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_d;
      frame_done_q <= state_d == DONE;
      busy_q       <= state_d != IDLE;
      if (win_d) begin
        win_row_q <= coordBits'(pos_row);
        win_col_q <= coordBits'(pos_col);
      end
    end
  end
  assign bus.bufEnable   = acc;
  assign bus.bufClear    = reset_n && bus.frameStart;
  assign bus.frameAbort  = reset_n && bus.frameStart && active;
  assign bus.windowValid = win_valid_q;
  assign bus.winRow      = win_row_q;
  assign bus.winCol      = win_col_q;
  assign bus.frameDone   = frame_done_q;
  assign bus.busy        = busy_q;
`ifdef WINDOW_CTRL_STATS_EN
  logic [15:0] drop_q, abort_q;
  logic        drop_inc;
  assign drop_inc = bus.pixelValid && !bus.frameStart && (state_q == IDLE || state_q == DONE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q  <= '0;
      abort_q <= '0;
    end else begin
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
      if (bus.frameAbort && abort_q != 16'hFFFF) abort_q <= abort_q + 1'b1;
    end
  end
  assign bus.dropCount  = drop_q;
  assign bus.abortCount = abort_q;
`endif
endmodule

// File: tb/tb_window_ctrl.sv
// tb_window_ctrl: directed plus random stimulus against a pixel-index frame model.
module tb_window_ctrl;
  localparam int W = 8, H = 6, K = 3, CW = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0, errors = 0;
  bit m_in, m_done, m_wv;
  int m_idx, m_wr, m_wc, m_drop, m_abort, win_seen;
  always #5 clk = ~clk;
  window_ctrl_if #(.coordBits(CW)) bus ();
  window_ctrl #(.rowWidth(W), .frameHeight(H), .kernelSize(K), .coordBits(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_done = 0; m_wv = 0; m_idx = 0;
    m_wr = 0; m_wc = 0; m_drop = 0; m_abort = 0;
  endtask

  task automatic check_outputs(input bit fs, input bit pv);
    chk("bufEnable", bus.bufEnable, fs | (pv & m_in));
    chk("bufClear", bus.bufClear, fs);
    chk("frameAbort", bus.frameAbort, fs & m_in);
    chk("frameDone", bus.frameDone, m_done);
    chk("busy", bus.busy, m_in | m_done);
    chk("windowValid", bus.windowValid, m_wv);
    chk("winRow", bus.winRow, m_wr);
    chk("winCol", bus.winCol, m_wc);
`ifdef WINDOW_CTRL_STATS_EN
    chk("dropCount", bus.dropCount, m_drop);
    chk("abortCount", bus.abortCount, m_abort);
`endif
  endtask

  // One cycle: drive, check against model, advance model by frame-index arithmetic.
  task automatic step(input bit fs, input bit pv);
    bit pix;
    int r, c;
    bus.frameStart = fs;
    bus.pixelValid = pv;
    #1;
    check_outputs(fs, pv);
    if (bus.windowValid) win_seen++;
    pix = pv && (fs || m_in);
    if (fs && m_in) m_abort++;
    if (pv && !fs && !m_in) m_drop++;
    if (fs) begin m_idx = 0; m_in = 1; end
    m_done = 0;
    m_wv = 0;
    if (pix) begin
      r = m_idx / W;
      c = m_idx % W;
      if (r >= K - 1 && c >= K - 1) begin m_wv = 1; m_wr = r; m_wc = c; end
      m_idx++;
      if (m_idx == W * H) begin m_in = 0; m_done = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input int stall_mod);
    for (int k = 1; m_in && k < 400; k++) step(0, stall_mod == 0 || (k % stall_mod) != stall_mod - 1);
  endtask

  initial begin
    bus.frameStart = 0;
    bus.pixelValid = 0;
    model_reset();
    #2;
    check_outputs(0, 0);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;
    // continuous frame
    win_seen = 0;
    step(1, 1);
    repeat (W * H - 1) step(0, 1);
    step(0, 0);
    chk("last_win_row", bus.winRow, 5);
    chk("last_win_col", bus.winCol, 7);
    step(0, 0);
    chk("win_count_cont", win_seen, (W - K + 1) * (H - K + 1));
    // stall every third cycle
    win_seen = 0;
    step(1, 1);
    finish_frame(3);
    step(0, 0);
    step(0, 0);
    chk("win_count_stall", win_seen, (W - K + 1) * (H - K + 1));
    // dropped beats in IDLE, then a frame
    repeat (5) step(0, 1);
    step(1, 1);
    finish_frame(0);
    step(0, 0);
    // restart at row 3 col 4, then frameStart in the DONE cycle
    step(1, 1);
    repeat (3 * W + 4 - 1) step(0, 1);
    step(1, 1);
    finish_frame(0);
    chk("done_pending", m_done, 1);
    step(1, 1);
    finish_frame(4);
    step(0, 0);
    // asynchronous reset mid-STREAM
    step(1, 1);
    repeat (30) step(0, 1);
    bus.pixelValid = 1;
    #3;
    reset_n = 0;
    #1;
    model_reset();
    check_outputs(0, 1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1;
    @(posedge clk);
    #1;
    repeat (4) step(0, 1);
    step(1, 1);
    repeat (12) step(0, 1);
    // random traffic
    repeat (500) step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
